pong_paddle_tracker: RTL and testbench

- Parametrised successor to the single-grid candidate-paddle finder; manages four paddles (top, bot, left, right) on a WIDTH x WIDTH pong field.
- Each enabled paddle moves toward a clamped target centred on the latest ball position, by at most STEP cells per clock.
- Flags a hit or miss per side when the ball reaches that side's edge cell.
- Sits between the ball-motion logic (position source) and the display/score logic.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_paddle_axis.sv | 59 +++++
 rtl/pong_paddle_tracker.sv | 56 +++++
 tb/tb_pong_paddle_tracker.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared side indices, FSM states and paddle limit helper.
package pong_pkg;
  localparam int TOP = 3;
  localparam int BOT = 2;
  localparam int LEFT = 1;
  localparam int RIGHT = 0;
  typedef enum logic [1:0] {IDLE, TRACK, SETTLED} state_t;
  typedef struct packed {
    int pmax;
    int pctr;
  } paddle_lim_t;
  function automatic paddle_lim_t paddle_lim(input int width, input int pad_len);
    paddle_lim_t l;
    l.pmax = width - 1 - pad_len;
    l.pctr = (width - pad_len) / 2;
    return l;
  endfunction
endpackage

// File: rtl/pong_paddle_axis.sv
// pong_paddle_axis: one paddle's target clamp, stepped motion and hit/miss compare.
import pong_pkg::*;
module pong_paddle_axis #(
  parameter int WIDTH = 16,
  parameter int BW = 4,
  parameter int PAD_LEN = 3,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] c,
  input  logic          on_edge,
  input  logic          load,
  input  logic          en,
  input  logic          move,
  output logic [BW-1:0] p,
  output logic          hit,
  output logic          miss,
  output logic          at,
  output logic          done,
  output logic          chg
);
  localparam paddle_lim_t LIM = paddle_lim(WIDTH, PAD_LEN);
  localparam logic [BW:0] PMAX = (BW+1)'(LIM.pmax);
  localparam logic [BW-1:0] PCTR = BW'(LIM.pctr);
  localparam logic [BW:0] HALF = (BW+1)'(PAD_LEN / 2);
  localparam logic [BW:0] LOW = (BW+1)'(1 + PAD_LEN / 2);
  localparam logic [BW:0] SPAN = (BW+1)'(PAD_LEN - 1);
  localparam logic [BW-1:0] STP = BW'(STEP);
  logic [BW-1:0] t, tc, t_nxt, p_nxt, d, st;
  logic [BW:0] tw;
  logic in_rng;
  always_comb begin
    tw = {1'b0, c} - HALF;
    tc = ({1'b0, c} < LOW) ? BW'(1) : (tw > PMAX) ? PMAX[BW-1:0] : tw[BW-1:0];
    t_nxt = load ? tc : t;
    d = (t > p) ? t - p : p - t;
    st = (d > STP) ? STP : d;
    p_nxt = !(move && en) ? p : (t > p) ? p + st : p - st;
    in_rng = (c >= p) && ({1'b0, c} <= {1'b0, p} + SPAN);
  end
  assign at = !en || (p == t);
  assign done = !en || (p_nxt == t_nxt);
  assign chg = en && (tc != t);
  // hit/miss judge against the plate held before this edge's move
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= PCTR;
      t <= PCTR;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      p <= p_nxt;
      if (load) t <= tc;
      hit <= load && en && on_edge && in_rng;
      miss <= load && en && on_edge && !in_rng;
    end
  end
endmodule

// File: rtl/pong_paddle_tracker.sv
// pong_paddle_tracker: four ball-tracking paddles with hit/miss flags and settle FSM.
import pong_pkg::*;
module pong_paddle_tracker #(
  parameter int WIDTH = 16,
  parameter int BIT_OF_WIDTH = 4,
  parameter int PAD_LEN = 3,
  parameter int STEP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*BIT_OF_WIDTH-1:0] pos,
  input  logic                      ball_valid,
  input  logic [3:0]                en,
  input  logic                      freeze,
  output logic [4*BIT_OF_WIDTH-1:0] plate,
  output logic [3:0]                hit,
  output logic [3:0]                miss,
  output logic                      settled,
  output logic                      bad_pos
);
  localparam int BW = BIT_OF_WIDTH;
  localparam logic [BW-1:0] EHI = BW'(WIDTH - 2);
  localparam logic [BW-1:0] WLIM = BW'(WIDTH - 1);
  state_t state;
  logic [BW-1:0] x, y;
  logic [3:0] on_edge, at, done, chg;
  logic bad, load, move;
  assign x = pos[2*BW-1:BW];
  assign y = pos[BW-1:0];
  assign bad = (x == '0) || (x >= WLIM) || (y == '0) || (y >= WLIM);
  assign load = ball_valid && !bad;
  assign move = (state == TRACK) && !freeze;
  assign on_edge = {y == BW'(1), y == EHI, x == BW'(1), x == EHI};
  assign settled = (state == SETTLED) && (&at);
  for (genvar i = 0; i < 4; i++) begin : g_axis
    pong_paddle_axis #(.WIDTH(WIDTH), .BW(BW), .PAD_LEN(PAD_LEN), .STEP(STEP)) u_axis (
      .clk(clk), .rst(rst), .c(i >= 2 ? x : y), .on_edge(on_edge[i]), .load(load),
      .en(en[i]), .move(move), .p(plate[i*BW +: BW]), .hit(hit[i]), .miss(miss[i]),
      .at(at[i]), .done(done[i]), .chg(chg[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bad_pos <= 1'b0;
    end else begin
      bad_pos <= ball_valid && bad;
      case (state)
        IDLE: state <= load ? TRACK : IDLE;
        TRACK: state <= (!freeze && (&done)) ? SETTLED : TRACK;
        SETTLED: state <= ((load && |chg) || !(&at)) ? TRACK : SETTLED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_paddle_tracker.sv
// tb_pong_paddle_tracker: directed scenario tasks with hand-computed expectations.
module tb_pong_paddle_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pos = '0;
  logic ball_valid = 1'b0;
  logic [3:0] en = 4'b1111;
  logic freeze = 1'b0;
  logic [15:0] plate;
  logic [3:0] hit, miss;
  logic settled, bad_pos;
  int cnt = 0;
  int errs = 0;
  always #5 clk = ~clk;
  pong_paddle_tracker dut (
    .clk(clk), .rst(rst), .pos(pos), .ball_valid(ball_valid), .en(en), .freeze(freeze),
    .plate(plate), .hit(hit), .miss(miss), .settled(settled), .bad_pos(bad_pos)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; ball_valid = 1'b0; freeze = 1'b0; en = 4'b1111;
    tick();
    rst = 1'b0;
  endtask
  task automatic strobe(input logic [3:0] bx, input logic [3:0] by);
    pos = {bx, by}; ball_valid = 1'b1;
    tick();
    ball_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    cnt++; if (plate !== 16'h6666) begin errs++; $display("FAIL reset_plate got %h exp 6666", plate); end
    cnt++; if ({hit, miss} !== 8'h00) begin errs++; $display("FAIL reset_hitmiss got %h exp 00", {hit, miss}); end
    cnt++; if ({settled, bad_pos} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b exp 00", {settled, bad_pos}); end
    tick(20);
    cnt++; if (plate !== 16'h6666 || settled !== 1'b0) begin errs++; $display("FAIL idle_hold got %h/%b exp 6666/0", plate, settled); end
  endtask
  task automatic test_track();
    strobe(4'd1, 4'd10);
    cnt++; if (miss !== 4'b0010 || hit !== 4'b0000) begin errs++; $display("FAIL track_miss got %b/%b exp 0010/0000", miss, hit); end
    cnt++; if (plate !== 16'h6666) begin errs++; $display("FAIL track_latency got %h exp 6666", plate); end
    tick();
    cnt++; if (plate !== 16'h5577 || miss !== 4'b0000) begin errs++; $display("FAIL track_step1 got %h/%b exp 5577/0000", plate, miss); end
    tick(2);
    cnt++; if (plate !== 16'h3399 || settled !== 1'b0) begin errs++; $display("FAIL track_step3 got %h/%b exp 3399/0", plate, settled); end
    tick();
    cnt++; if (plate !== 16'h2299 || settled !== 1'b0) begin errs++; $display("FAIL track_step4 got %h/%b exp 2299/0", plate, settled); end
    tick();
    cnt++; if (plate !== 16'h1199 || settled !== 1'b1) begin errs++; $display("FAIL track_settle got %h/%b exp 1199/1", plate, settled); end
  endtask
  task automatic test_hit();
    strobe(4'd1, 4'd10);
    cnt++; if (hit !== 4'b0010 || miss !== 4'b0000) begin errs++; $display("FAIL hit_left got %b/%b exp 0010/0000", hit, miss); end
    cnt++; if (settled !== 1'b1) begin errs++; $display("FAIL hit_settled got %b exp 1", settled); end
    tick();
    cnt++; if (plate !== 16'h1199 || settled !== 1'b1 || hit !== 4'b0000) begin errs++; $display("FAIL hit_hold got %h/%b/%b exp 1199/1/0000", plate, settled, hit); end
  endtask
  task automatic test_clamp();
    do_reset();
    strobe(4'd14, 4'd14);
    cnt++; if (miss !== 4'b0101 || hit !== 4'b0000) begin errs++; $display("FAIL clamp_corner got %b/%b exp 0101/0000", miss, hit); end
    tick(5);
    cnt++; if (plate !== 16'hBBBB || settled !== 1'b0) begin errs++; $display("FAIL clamp_step5 got %h/%b exp BBBB/0", plate, settled); end
    tick();
    cnt++; if (plate !== 16'hCCCC || settled !== 1'b1) begin errs++; $display("FAIL clamp_max got %h/%b exp CCCC/1", plate, settled); end
    tick(2);
    cnt++; if (plate !== 16'hCCCC) begin errs++; $display("FAIL clamp_hold got %h exp CCCC", plate); end
  endtask
  task automatic test_freeze();
    do_reset();
    freeze = 1'b1;
    strobe(4'd5, 4'd2);
    tick(10);
    cnt++; if (plate !== 16'h6666 || settled !== 1'b0) begin errs++; $display("FAIL freeze_hold got %h/%b exp 6666/0", plate, settled); end
    freeze = 1'b0;
    tick();
    cnt++; if (plate !== 16'h5555) begin errs++; $display("FAIL freeze_resume got %h exp 5555", plate); end
    tick(2);
    cnt++; if (plate !== 16'h4433) begin errs++; $display("FAIL freeze_step3 got %h exp 4433", plate); end
  endtask
  task automatic test_bad_pos();
    do_reset();
    strobe(4'd0, 4'd7);
    cnt++; if (bad_pos !== 1'b1 || {hit, miss} !== 8'h00) begin errs++; $display("FAIL bad_x0 got %b/%h exp 1/00", bad_pos, {hit, miss}); end
    tick();
    cnt++; if (bad_pos !== 1'b0) begin errs++; $display("FAIL bad_pulse got %b exp 0", bad_pos); end
    strobe(4'd7, 4'd15);
    cnt++; if (bad_pos !== 1'b1) begin errs++; $display("FAIL bad_y15 got %b exp 1", bad_pos); end
    tick(3);
    cnt++; if (plate !== 16'h6666 || settled !== 1'b0) begin errs++; $display("FAIL bad_nomove got %h/%b exp 6666/0", plate, settled); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    strobe(4'd1, 4'd10);
    tick();
    strobe(4'd14, 4'd14);
    cnt++; if (plate !== 16'h4488 || miss !== 4'b0101) begin errs++; $display("FAIL b2b_retarget got %h/%b exp 4488/0101", plate, miss); end
    tick();
    cnt++; if (plate !== 16'h5599) begin errs++; $display("FAIL b2b_nostall got %h exp 5599", plate); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    strobe(4'd1, 4'd10);
    tick();
    rst = 1'b1;
    tick();
    cnt++; if (plate !== 16'h6666 || settled !== 1'b0) begin errs++; $display("FAIL rstmid_plate got %h/%b exp 6666/0", plate, settled); end
    rst = 1'b0;
    tick(3);
    cnt++; if (plate !== 16'h6666) begin errs++; $display("FAIL rstmid_idle got %h exp 6666", plate); end
  endtask
  task automatic test_enable();
    do_reset();
    en = 4'b0111;
    strobe(4'd5, 4'd1);
    cnt++; if ({hit, miss} !== 8'h00) begin errs++; $display("FAIL en_noflag got %h exp 00", {hit, miss}); end
    tick(5);
    cnt++; if (plate !== 16'h6411 || settled !== 1'b1) begin errs++; $display("FAIL en_partial got %h/%b exp 6411/1", plate, settled); end
    en = 4'b1111;
    #1;
    cnt++; if (settled !== 1'b0) begin errs++; $display("FAIL en_comb got %b exp 0", settled); end
    tick();
    cnt++; if (plate !== 16'h6411) begin errs++; $display("FAIL en_retrack got %h exp 6411", plate); end
    tick(2);
    cnt++; if (plate !== 16'h4411 || settled !== 1'b1) begin errs++; $display("FAIL en_settle got %h/%b exp 4411/1", plate, settled); end
  endtask
  initial begin
    test_reset();
    test_track();
    test_hit();
    test_clamp();
    test_freeze();
    test_bad_pos();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
